fetch_sequencer: RTL

//   Program-counter and fetch controller for the single-cycle datapath's instruction memory.
//   - Drives the combinational instruction-memory read address.
//   - Registers the returned word and hands it to decode over a valid/ready handshake.
//   - Handles stalls, branch/jump redirects, start/restart and halt.
//   - Sits between the instruction memory and the decode/control stage.

---
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program counter and fetch controller for the instruction memory of the
//   single-cycle datapath. It drives the combinational read address,
//   registers the returned word and hands it to decode over a valid/ready
//   handshake. It also handles stalls, branch/jump redirects,
//   start/restart, halt-word detection and end-of-memory wrap or halt.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           begin fetching at address 0 (IDLE/HALTED only)
//   imem_addr       read address to instruction memory (= pc)
//   imem_rdata      word returned combinationally for imem_addr
//   instr_out       registered instruction presented to decode
//   pc_out          address instr_out was fetched from
//   instr_valid     instr_out/pc_out valid
//   instr_ready     decode accepts instr_out this cycle
//   redirect_valid  taken branch/jump: flush and refetch from redirect_addr
//   redirect_addr   new fetch address
//   busy            state is FETCH
//   halted          state is HALTED
module fetch_sequencer #(
  parameter int                 ADDR_W    = 3,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF,
  parameter bit                 WRAP_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_MAX = '1;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  pc_out_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               valid_nxt;
  logic               slot_free;

  // The output register can take a new word when it is empty or its
  // current word is being accepted this cycle.
  assign slot_free = !instr_valid || instr_ready;
  assign imem_addr = pc;
  assign busy      = (state == FETCH);
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_out   <= instr_nxt;
      pc_out      <= pc_out_nxt;
      instr_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = instr_out;
    pc_out_nxt = pc_out;
    valid_nxt  = instr_valid;

    // Drain applies in every state, so a word left pending when the
    // sequencer halts is still handed over to decode.
    if (instr_valid && instr_ready) begin
      valid_nxt = 1'b0;
    end

    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
        end
      end

      FETCH: begin
        // A redirect flushes the output even during a stall, and it takes
        // priority over capture, halt detection and wrap-halt.
        if (redirect_valid) begin
          pc_nxt    = redirect_addr;
          valid_nxt = 1'b0;
        end else if (slot_free) begin
          if (imem_rdata == HALT_WORD) begin
            // The halt word is never presented; pc stays on it.
            state_nxt = HALTED;
          end else begin
            instr_nxt  = imem_rdata;
            pc_out_nxt = pc;
            valid_nxt  = 1'b1;
            if (!WRAP_EN && (pc == PC_MAX)) begin
              state_nxt = HALTED;
              pc_nxt    = '0;
            end else begin
              pc_nxt = pc + 1'b1;
            end
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
